// File: rtl/aes_byte_loader.sv
// aes_byte_loader: framed byte-stream front end for aes_core (key/block assembly, init/next sequencing, result serialisation).
// Latency: core_init/core_next one cycle after the last frame byte is accepted; m_valid one cycle after the sampled core_done edge.
// Backpressure: s_ready is low in KEY_WAIT, BLK_WAIT and TX; m_data holds while m_ready is low.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   s_data/s_valid/s_ready       : framed input byte stream (header byte + payload)
//   m_data/m_valid/m_ready       : result byte stream, MSB byte of the result first
//   core_init/core_key/core_keylen/core_key_ready : key schedule handshake to aes_core
//   core_next/core_block/core_done/core_result/core_error : block handshake to aes_core
//   key_valid, busy, err_code    : status (err_code 1 = bad header, 2 = block before key, 3 = core error/timeout)
module aes_byte_loader #(
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [7:0]   m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         core_init,
   output logic [255:0] core_key,
   output logic [1:0]   core_keylen,
   input  logic         core_key_ready,
   output logic [127:0] core_block,
   output logic         core_next,
   input  logic         core_done,
   input  logic [127:0] core_result,
   input  logic         core_error,
   output logic         key_valid,
   output logic         busy,
   output logic [1:0]   err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY_RX,
      S_KEY_WAIT,
      S_BLK_RX,
      S_DISCARD,
      S_BLK_WAIT,
      S_TX
   } state_t;

   state_t         state_q, state_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [15:0]    wait_q, wait_d;
   logic [255:0]   key_q, key_d;
   logic [1:0]     keylen_q, keylen_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   res_q, res_d;
   logic           key_valid_q, key_valid_d;
   logic           init_q, init_d;
   logic           next_q, next_d;
   logic           kr_q, kr_d;
   logic           done_q, done_d;
   logic [1:0]     err_q, err_d;

   logic           accept;
   logic           is_key_hdr;
   logic           is_blk_hdr;
   logic           key_edge;
   logic           done_edge;
   logic           abort;
   logic [4:0]     key_last;

   assign s_ready    = rst_n & ((state_q == S_IDLE) | (state_q == S_KEY_RX) |
                                (state_q == S_BLK_RX) | (state_q == S_DISCARD));
   assign accept     = s_valid & s_ready;
   assign is_key_hdr = (s_data[7:2] == 6'b010000) && (s_data[1:0] != 2'd3);
   assign is_blk_hdr = (s_data == 8'h80);

   // Edge detection on the core status levels; a level that was already high
   // when the wait began does not count as completion.
   assign key_edge   = core_key_ready & ~kr_q;
   assign done_edge  = core_done & ~done_q;
   // The counter starts at 0 on entry, so this fires on the TIMEOUT-th wait cycle.
   assign abort      = core_error | (wait_q == 16'(TIMEOUT - 1));

   always_comb begin
      case (keylen_q)
         2'd0:    key_last = 5'd15;
         2'd1:    key_last = 5'd23;
         default: key_last = 5'd31;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      key_d       = key_q;
      keylen_d    = keylen_q;
      blk_d       = blk_q;
      res_d       = res_q;
      key_valid_d = key_valid_q;
      err_d       = err_q;
      init_d      = 1'b0;
      next_d      = 1'b0;
      kr_d        = core_key_ready;
      done_d      = core_done;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = 5'd0;
               if (is_key_hdr) begin
                  key_d       = '0;
                  keylen_d    = s_data[1:0];
                  key_valid_d = 1'b0;
                  err_d       = 2'd0;
                  state_d     = S_KEY_RX;
               end else if (is_blk_hdr) begin
                  if (key_valid_q) begin
                     blk_d   = '0;
                     err_d   = 2'd0;
                     state_d = S_BLK_RX;
                  end else begin
                     err_d   = 2'd2;
                     state_d = S_DISCARD;
                  end
               end else begin
                  err_d = 2'd1;
               end
            end
         end

         S_KEY_RX: begin
            if (accept) begin
               // Byte n lands at [255-8n -: 8]: key is left-aligned, first byte MSB.
               key_d = key_q | ({s_data, 248'b0} >> {cnt_q, 3'b000});
               if (cnt_q == key_last) begin
                  cnt_d   = 5'd0;
                  wait_d  = 16'd0;
                  init_d  = 1'b1;
                  state_d = S_KEY_WAIT;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         S_KEY_WAIT: begin
            wait_d = wait_q + 16'd1;
            if (abort) begin
               err_d       = 2'd3;
               key_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else if (key_edge) begin
               key_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         S_BLK_RX: begin
            if (accept) begin
               blk_d = blk_q | ({s_data, 120'b0} >> {cnt_q[3:0], 3'b000});
               if (cnt_q == 5'd15) begin
                  cnt_d   = 5'd0;
                  wait_d  = 16'd0;
                  next_d  = 1'b1;
                  state_d = S_BLK_WAIT;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         S_DISCARD: begin
            // Swallow the payload of a rejected block so the next byte is a header.
            if (accept) begin
               if (cnt_q == 5'd15) begin
                  cnt_d   = 5'd0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         S_BLK_WAIT: begin
            wait_d = wait_q + 16'd1;
            if (abort) begin
               err_d       = 2'd3;
               key_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else if (done_edge) begin
               res_d   = core_result;
               cnt_d   = 5'd0;
               state_d = S_TX;
            end
         end

         S_TX: begin
            if (m_ready) begin
               res_d = {res_q[119:0], 8'h00};
               if (cnt_q == 5'd15) begin
                  cnt_d   = 5'd0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         wait_q      <= 16'd0;
         key_q       <= '0;
         keylen_q    <= 2'd0;
         blk_q       <= '0;
         res_q       <= '0;
         key_valid_q <= 1'b0;
         err_q       <= 2'd0;
         init_q      <= 1'b0;
         next_q      <= 1'b0;
         kr_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         key_q       <= key_d;
         keylen_q    <= keylen_d;
         blk_q       <= blk_d;
         res_q       <= res_d;
         key_valid_q <= key_valid_d;
         err_q       <= err_d;
         init_q      <= init_d;
         next_q      <= next_d;
         kr_q        <= kr_d;
         done_q      <= done_d;
      end
   end

   assign m_data      = res_q[127:120];
   assign m_valid     = (state_q == S_TX);
   assign core_init   = init_q;
   assign core_next   = next_q;
   assign core_key    = key_q;
   assign core_keylen = keylen_q;
   assign core_block  = blk_q;
   assign key_valid   = key_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign err_code    = err_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed bench for aes_byte_loader with a behavioural aes_core stand-in
// and an output-stream scoreboard checked every cycle.
module tb_aes_byte_loader;
   localparam int TO = 40;

   logic         clk;
   logic         rst_n;
   logic [7:0]   s_data;
   logic         s_valid;
   logic         s_ready;
   logic [7:0]   m_data;
   logic         m_valid;
   logic         m_ready;
   logic         core_init;
   logic [255:0] core_key;
   logic [1:0]   core_keylen;
   logic         core_key_ready;
   logic [127:0] core_block;
   logic         core_next;
   logic         core_done;
   logic [127:0] core_result;
   logic         core_error;
   logic         key_valid;
   logic         busy;
   logic [1:0]   err_code;

   int checks = 0;
   int failures = 0;
   int n_init = 0;
   int n_next = 0;
   int core_mode = 0;          // 0 = answers, 1 = raises core_error, 2 = silent
   int bp_mode = 0;
   logic [127:0] core_res_val = '0;
   logic [7:0] exp_q[$];

   aes_byte_loader #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .core_init(core_init), .core_key(core_key), .core_keylen(core_keylen),
      .core_key_ready(core_key_ready), .core_block(core_block), .core_next(core_next),
      .core_done(core_done), .core_result(core_result), .core_error(core_error),
      .key_valid(key_valid), .busy(busy), .err_code(err_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Key expected from a run of n incrementing bytes, left-aligned, first byte at the top.
   function automatic logic [255:0] key_model(input int n, input logic [7:0] first);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[255 - 8*i -: 8] = 8'(first + i);
      return v;
   endfunction

   task automatic push_result(input logic [127:0] r);
      for (int i = 0; i < 16; i++) exp_q.push_back(r[127 - 8*i -: 8]);
   endtask

   // aes_core stand-in: key ready 3 cycles after init, result/error after next.
   initial begin
      int kr_cnt;
      int dn_cnt;
      kr_cnt = 0;
      dn_cnt = 0;
      core_key_ready = 1'b0;
      core_done = 1'b0;
      core_error = 1'b0;
      core_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (core_init) begin
            core_key_ready = 1'b0;
            kr_cnt = 3;
         end else if (kr_cnt > 0) begin
            kr_cnt--;
            if (kr_cnt == 0) core_key_ready = 1'b1;
         end
         core_done = 1'b0;
         core_error = 1'b0;
         if (core_next) begin
            dn_cnt = (core_mode == 0) ? 5 : (core_mode == 1) ? 2 : 0;
         end else if (dn_cnt > 0) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
               if (core_mode == 1) core_error = 1'b1;
               else begin
                  core_done = 1'b1;
                  core_result = core_res_val;
               end
            end
         end
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = (bp_mode != 0) ? ~m_ready : 1'b1;
      end
   end

   // Per-cycle compare of the output stream and pulse discipline.
   always @(negedge clk) begin
      if (rst_n) begin
         if (core_init) n_init++;
         if (core_next) n_next++;
         chk("pulse_overlap", {255'b0, core_init & core_next}, 256'd0);
         if (m_valid) begin
            chk("tx_s_ready", {255'b0, s_ready}, 256'd0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL m_valid_unexpected: got m_data %h expected no output", m_data);
            end else begin
               chk("m_data", {248'b0, m_data}, {248'b0, exp_q[0]});
               if (m_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      int c;
      c = 0;
      s_data = b;
      s_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         c++;
      end while (!acc && c < 200);
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL s_ready_timeout: byte %h not accepted, expected acceptance within 200 cycles", b);
      end
   endtask

   task automatic send_frame(input logic [7:0] hdr, input int n, input logic [7:0] first);
      send_byte(hdr);
      for (int i = 0; i < n; i++) send_byte(8'(first + i));
      s_valid = 1'b0;
   endtask

   task automatic wait_key_valid();
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!key_valid && c < 50);
      chk("key_valid_rise", {255'b0, key_valid}, 256'd1);
      chk("key_done_idle", {255'b0, busy}, 256'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (busy && c < 200);
      chk("return_idle", {255'b0, busy}, 256'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c;
      int n0;
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_s_ready_low", {255'b0, s_ready}, 256'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_s_ready", {255'b0, s_ready}, 256'd1);
      chk("rst_outs", {248'b0, m_valid, core_init, core_next, key_valid, busy, err_code, core_keylen[0]}, 256'd0);
      chk("rst_keylen", {254'b0, core_keylen}, 256'd0);
      chk("rst_key", core_key, 256'd0);
      chk("rst_block", {128'b0, core_block}, 256'd0);
      chk("rst_m_data", {248'b0, m_data}, 256'd0);
      @(posedge clk);
      #1;

      // Illegal header, then a block before any key.
      send_byte(8'hFF);
      s_valid = 1'b0;
      @(negedge clk);
      chk("bad_hdr_err", {254'b0, err_code}, 256'd1);
      chk("bad_hdr_idle", {255'b0, busy}, 256'd0);
      @(posedge clk);
      #1;
      n0 = n_next;
      send_frame(8'h80, 16, 8'h01);
      @(negedge clk);
      chk("nokey_err", {254'b0, err_code}, 256'd2);
      chk("discard_idle", {255'b0, busy}, 256'd0);
      chk("discard_no_next", 256'(n_next), 256'(n0));
      @(posedge clk);
      #1;

      // 256-bit key load.
      n0 = n_init;
      send_frame(8'h42, 32, 8'h01);
      @(negedge clk);
      chk("init_pulse", {255'b0, core_init}, 256'd1);
      chk("key256_lit", core_key, 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20);
      chk("key256_model", core_key, key_model(32, 8'h01));
      chk("keylen2", {254'b0, core_keylen}, 256'd2);
      chk("key_hdr_clears_err", {254'b0, err_code}, 256'd0);
      chk("wait_s_ready", {255'b0, s_ready}, 256'd0);
      @(negedge clk);
      chk("init_one_cycle", {255'b0, core_init}, 256'd0);
      wait_key_valid();
      chk("init_count", 256'(n_init - n0), 256'd1);

      // Block round trip.
      core_res_val = {16{8'hA5}};
      push_result(core_res_val);
      send_frame(8'h80, 16, 8'h01);
      @(negedge clk);
      chk("next_after_last", {255'b0, core_next}, 256'd1);
      chk("block_lit", {128'b0, core_block}, {128'b0, 128'h0102030405060708090a0b0c0d0e0f10});
      chk("blk_busy", {255'b0, busy}, 256'd1);
      @(negedge clk);
      chk("next_one_cycle", {255'b0, core_next}, 256'd0);
      wait_idle();
      chk("rt_all_bytes", 256'(exp_q.size()), 256'd0);
      chk("rt_m_valid_low", {255'b0, m_valid}, 256'd0);

      // Output back-pressure with distinct bytes.
      core_res_val = 128'h00112233445566778899aabbccddeeff;
      push_result(core_res_val);
      bp_mode = 1;
      send_frame(8'h80, 16, 8'h20);
      wait_idle();
      bp_mode = 0;
      chk("bp_all_bytes", 256'(exp_q.size()), 256'd0);

      // 128-bit key load; previous key_valid is dropped by the header.
      send_frame(8'h40, 16, 8'h01);
      @(negedge clk);
      chk("key128_lit", core_key, {128'h0102030405060708090a0b0c0d0e0f10, 128'h0});
      chk("keylen0", {254'b0, core_keylen}, 256'd0);
      chk("key_hdr_clears_kv", {255'b0, key_valid}, 256'd0);
      wait_key_valid();

      // Keylen 3 is an illegal header and leaves the key alone.
      send_byte(8'h43);
      s_valid = 1'b0;
      @(negedge clk);
      chk("ll3_err", {254'b0, err_code}, 256'd1);
      chk("ll3_kv_kept", {255'b0, key_valid}, 256'd1);
      @(posedge clk);
      #1;

      // Core error during BLK_WAIT.
      core_mode = 1;
      send_frame(8'h80, 16, 8'h11);
      @(negedge clk);
      chk("blk_hdr_clears_err", {254'b0, err_code}, 256'd0);
      wait_idle();
      chk("core_err_code", {254'b0, err_code}, 256'd3);
      chk("core_err_kv", {255'b0, key_valid}, 256'd0);

      // 192-bit key, then a silent core to hit the timeout.
      core_mode = 0;
      send_frame(8'h41, 24, 8'h30);
      @(negedge clk);
      chk("key192_model", core_key, key_model(24, 8'h30));
      chk("keylen1", {254'b0, core_keylen}, 256'd1);
      wait_key_valid();
      core_mode = 2;
      send_frame(8'h80, 16, 8'h01);
      @(negedge clk);
      chk("to_next", {255'b0, core_next}, 256'd1);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (busy && c < TO + 10);
      checks++;
      if (c < TO || c > TO + 1) begin
         failures++;
         $display("FAIL timeout_cycles: got %0d expected %0d or %0d", c, TO, TO + 1);
      end
      chk("to_err_code", {254'b0, err_code}, 256'd3);
      chk("to_kv", {255'b0, key_valid}, 256'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of KEY_RX.
      core_mode = 0;
      n0 = n_init;
      send_byte(8'h42);
      for (int i = 0; i < 5; i++) send_byte(8'(8'h01 + i));
      s_valid = 1'b0;
      @(negedge clk);
      chk("mid_key_busy", {255'b0, busy}, 256'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mrst_s_ready", {255'b0, s_ready}, 256'd0);
      chk("mrst_outs", {249'b0, m_valid, core_init, core_next, key_valid, busy, err_code}, 256'd0);
      chk("mrst_key", core_key, 256'd0);
      chk("mrst_no_init", 256'(n_init), 256'(n0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mrst_idle_ready", {255'b0, s_ready}, 256'd1);
      chk("mrst_idle", {255'b0, busy}, 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
